// File: rtl/instr_fetch_buffer_if.sv
// Fetch-side bundle: redirect input, instruction-memory request/grant/response
// channel and the buffered instruction stream presented to decode.
interface instr_fetch_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              redirect_valid;
  logic [31:0]       redirect_addr;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              out_ready;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    input  redirect_valid, redirect_addr,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_instr, out_pc, occupancy,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_addr,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_instr, out_pc, occupancy,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Sequential instruction fetcher with a small {pc, instr} FIFO; a redirect
// flushes the buffer and drops any response still in flight.
module instr_fetch_buffer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_buffer_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_nxt;
  logic [31:0]       fetch_pc, fetch_pc_nxt;
  logic              drop, drop_nxt;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_post;
  logic [31:0]       pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];
  logic              resp, push, pop;

  assign resp = (state == WAIT) && bus.imem_rvalid;
  assign pop  = (count != '0) && bus.out_ready && !bus.redirect_valid;
  assign push = resp && !drop && !bus.redirect_valid;

  always_comb begin
    count_post = count;
    if (push && !pop)
      count_post = count + CNT_W'(1);
    else if (pop && !push)
      count_post = count - CNT_W'(1);
  end

  // Redirect handling overrides the normal fetch sequencing below.
  always_comb begin
    state_nxt    = state;
    drop_nxt     = drop;
    fetch_pc_nxt = fetch_pc;
    unique case (state)
      IDLE: if (count_post < FULL) state_nxt = REQ;
      REQ:  if (bus.imem_gnt) state_nxt = WAIT;
      WAIT: if (bus.imem_rvalid) begin
              drop_nxt  = 1'b0;
              state_nxt = (count_post < FULL) ? REQ : IDLE;
            end
      default: state_nxt = IDLE;
    endcase
    if (push)
      fetch_pc_nxt = fetch_pc + 32'd4;
    if (bus.redirect_valid) begin
      fetch_pc_nxt = {bus.redirect_addr[31:2], 2'b00};
      unique case (state)
        IDLE: state_nxt = REQ;
        REQ: begin
          if (bus.imem_gnt) begin
            state_nxt = WAIT;
            drop_nxt  = 1'b1;
          end else begin
            state_nxt = REQ;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            state_nxt = REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt = WAIT;
            drop_nxt  = 1'b1;
          end
        end
        default: state_nxt = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_ADDR;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      drop     <= drop_nxt;
      if (bus.redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_post;
      end
    end
  end

  // Entry storage carries no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = (state == REQ);
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = pc_mem[rd_ptr];
  assign bus.out_instr = instr_mem[rd_ptr];
  assign bus.occupancy = count;
endmodule
